// File: rtl/delay_probe_tx_gen.sv
// Timestamped Ethernet probe frame generator driving a 32-bit big-endian Avalon-ST MAC sink.
// Each frame carries a sequence number and the 64-bit system time captured at the SOP handshake.
module delay_probe_tx_gen #(
  parameter int unsigned FRAME_WORDS = 15,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter logic [31:0] FILL_WORD   = 32'hA5A5_A5A5
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] frame_cnt_i,
  input  logic [31:0] gap_i,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  output logic [31:0] src_data_o,
  output logic        src_valid_o,
  input  logic        src_ready_i,
  output logic        src_sop_o,
  output logic        src_eop_o,
  output logic [1:0]  src_empty_o,
  output logic        busy_o,
  output logic [63:0] ts_o,
  output logic [63:0] tx_stamp_o,
  output logic [31:0] tx_seq_o,
  output logic        tx_stamp_valid_o,
  output logic [1:0]  dbg_state_o
);

  localparam int WW = $clog2(FRAME_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] word_q;
  logic [31:0]   frame_cnt_q;
  logic [31:0]   gap_q;
  logic [31:0]   gap_cnt_q;
  logic [31:0]   seq_q;
  logic [31:0]   sent_q;
  logic [47:0]   dst_q;
  logic [47:0]   src_q;
  logic          stop_pend_q;

  logic        beat;
  logic        sop_beat;
  logic        eop_beat;
  logic        stop_req;
  logic        burst_done;
  logic        start_ok;
  logic [31:0] sent_inc;
  logic [31:0] word_idx;
  logic [31:0] word_data;

  // Handshake: a beat transfers on a cycle with src_valid_o & src_ready_i (ready latency 0).
  // Valid is high for the whole of SEND, so data/sop/eop only change after a transfer.
  assign beat       = (state_q == SEND) & src_ready_i;
  assign sop_beat   = beat & (word_q == '0);
  assign eop_beat   = beat & (word_q == LAST_WORD);
  assign stop_req   = stop_pend_q | stop_i;
  assign sent_inc   = sent_q + 32'd1;
  assign burst_done = stop_req | ((frame_cnt_q != 32'd0) && (sent_inc == frame_cnt_q));

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (eop_beat) state_d = burst_done ? IDLE : GAP;
      end
      GAP: begin
        if (stop_req)                 state_d = IDLE;
        else if (gap_cnt_q == 32'd1)  state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q          <= IDLE;
      word_q           <= '0;
      frame_cnt_q      <= '0;
      gap_q            <= '0;
      gap_cnt_q        <= '0;
      seq_q            <= '0;
      sent_q           <= '0;
      dst_q            <= '0;
      src_q            <= '0;
      stop_pend_q      <= 1'b0;
      ts_o             <= '0;
      tx_stamp_o       <= '0;
      tx_seq_o         <= '0;
      tx_stamp_valid_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      ts_o             <= ts_o + 64'd1;
      tx_stamp_valid_o <= sop_beat;
      if (sop_beat) begin
        tx_stamp_o <= ts_o;
        tx_seq_o   <= seq_q;
      end
      if (start_ok) begin
        frame_cnt_q <= frame_cnt_i;
        gap_q       <= (gap_i == 32'd0) ? 32'd1 : gap_i;
        dst_q       <= dst_mac_i;
        src_q       <= src_mac_i;
        seq_q       <= '0;
        sent_q      <= '0;
        word_q      <= '0;
      end
      if (beat) word_q <= eop_beat ? '0 : word_q + 1'b1;
      if (eop_beat) begin
        sent_q <= sent_inc;
        seq_q  <= seq_q + 32'd1;
      end
      if (state_q == SEND && state_d == GAP) gap_cnt_q <= gap_q;
      else if (state_q == GAP)               gap_cnt_q <= gap_cnt_q - 32'd1;
      // A pending stop survives until the burst actually returns to IDLE.
      if (state_d == IDLE)                   stop_pend_q <= 1'b0;
      else if (stop_i && state_q != IDLE)    stop_pend_q <= 1'b1;
    end
  end

  // w5/w6 read the registered stamp, which is fixed several beats before they go out.
  assign word_idx = 32'(word_q);
  always_comb begin
    word_data = FILL_WORD;
    case (word_idx)
      32'd0: word_data = dst_q[47:16];
      32'd1: word_data = {dst_q[15:0], src_q[47:32]};
      32'd2: word_data = src_q[31:0];
      32'd3: word_data = {ETHERTYPE, 16'h0000};
      32'd4: word_data = seq_q;
      32'd5: word_data = tx_stamp_o[63:32];
      32'd6: word_data = tx_stamp_o[31:0];
      default: word_data = FILL_WORD;
    endcase
  end

  assign src_valid_o = (state_q == SEND);
  assign src_data_o  = src_valid_o ? word_data : 32'd0;
  assign src_sop_o   = src_valid_o & (word_q == '0);
  assign src_eop_o   = src_valid_o & (word_q == LAST_WORD);
  assign src_empty_o = 2'b00;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_delay_probe_tx_gen.sv
// Bench for delay_probe_tx_gen: a frame-level model builds each expected frame at its SOP handshake
// and a negedge monitor checks every beat, the stamp pulse and ts_o; directed tests pin burst shape.
module tb_delay_probe_tx_gen;

  localparam int FW = 15;

  logic        clk = 1'b0;
  logic        srst_i;
  logic        start_i;
  logic        stop_i;
  logic [31:0] frame_cnt_i;
  logic [31:0] gap_i;
  logic [47:0] dst_mac_i;
  logic [47:0] src_mac_i;
  logic [31:0] src_data_o;
  logic        src_valid_o;
  logic        src_ready_i;
  logic        src_sop_o;
  logic        src_eop_o;
  logic [1:0]  src_empty_o;
  logic        busy_o;
  logic [63:0] ts_o;
  logic [63:0] tx_stamp_o;
  logic [31:0] tx_seq_o;
  logic        tx_stamp_valid_o;
  logic [1:0]  dbg_state_o;

  delay_probe_tx_gen dut (
    .clk_i(clk), .srst_i(srst_i), .start_i(start_i), .stop_i(stop_i),
    .frame_cnt_i(frame_cnt_i), .gap_i(gap_i), .dst_mac_i(dst_mac_i), .src_mac_i(src_mac_i),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o), .src_ready_i(src_ready_i),
    .src_sop_o(src_sop_o), .src_eop_o(src_eop_o), .src_empty_o(src_empty_o),
    .busy_o(busy_o), .ts_o(ts_o), .tx_stamp_o(tx_stamp_o), .tx_seq_o(tx_seq_o),
    .tx_stamp_valid_o(tx_stamp_valid_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #4 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  logic [31:0] pseq_q[$];
  logic [63:0] pstamp_q[$];
  int          gap_lens[$];

  bit          chk_en = 0;
  bit          in_frame = 0;
  bit          exp_pulse = 0;
  bit          stall_pend = 0;
  bit          gap_counting = 0;
  int          beat_idx = 0;
  int          sop_cnt = 0;
  int          eop_cnt = 0;
  int          gap_len = 0;
  logic [63:0] exp_ts = '0;
  logic [63:0] cur_ts;
  logic [63:0] start_ts = '0;
  logic [63:0] pulse_stamp;
  logic [31:0] pulse_seq;
  logic [31:0] exp_seq = '0;
  logic [31:0] hold_data;
  logic        hold_sop;
  logic        hold_eop;
  logic [47:0] cfg_dst = '0;
  logic [47:0] cfg_src = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_word(input int w, input logic [47:0] d, input logic [47:0] s,
                                             input logic [31:0] q, input logic [63:0] st);
    case (w)
      0:       return d[47:16];
      1:       return {d[15:0], s[47:32]};
      2:       return s[31:0];
      3:       return 32'h88B5_0000;
      4:       return q;
      5:       return st[63:32];
      6:       return st[31:0];
      default: return 32'hA5A5_A5A5;
    endcase
  endfunction

  // ---------------- monitor / model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ts", ts_o, exp_ts);
      chk("empty", {62'd0, src_empty_o}, 64'd0);
      chk("stamp_valid", {63'd0, tx_stamp_valid_o}, {63'd0, exp_pulse});
      if (exp_pulse) begin
        chk("tx_stamp", tx_stamp_o, pulse_stamp);
        chk("tx_seq", {32'd0, tx_seq_o}, {32'd0, pulse_seq});
      end
      if (tx_stamp_valid_o) begin
        pseq_q.push_back(tx_seq_o);
        pstamp_q.push_back(tx_stamp_o);
      end
      if (stall_pend) begin
        chk("hold_valid", {63'd0, src_valid_o}, 64'd1);
        chk("hold_data", {32'd0, src_data_o}, {32'd0, hold_data});
        chk("hold_sop", {63'd0, src_sop_o}, {63'd0, hold_sop});
        chk("hold_eop", {63'd0, src_eop_o}, {63'd0, hold_eop});
      end
      if (in_frame) chk("valid_mid_frame", {63'd0, src_valid_o}, 64'd1);
      if (!busy_o)  chk("valid_idle", {63'd0, src_valid_o}, 64'd0);
    end
    exp_pulse  = 0;
    stall_pend = 0;
    if (srst_i) begin
      chk_en       = 1;
      exp_ts       = '0;
      in_frame     = 0;
      beat_idx     = 0;
      gap_counting = 0;
      exp_q.delete();
    end else if (chk_en) begin
      cur_ts = exp_ts;
      exp_ts = exp_ts + 64'd1;
      if (start_i && !busy_o) begin
        cfg_dst  = dst_mac_i;
        cfg_src  = src_mac_i;
        exp_seq  = '0;
        start_ts = cur_ts;
      end
      if (gap_counting) begin
        if (!busy_o) gap_counting = 0;
        else if (src_valid_o) begin
          gap_lens.push_back(gap_len);
          gap_counting = 0;
        end else gap_len++;
      end
      if (src_valid_o && src_ready_i) begin
        if (!in_frame) begin
          for (int w = 0; w < FW; w++) exp_q.push_back(frame_word(w, cfg_dst, cfg_src, exp_seq, cur_ts));
          in_frame    = 1;
          beat_idx    = 0;
          sop_cnt++;
          exp_pulse   = 1;
          pulse_stamp = cur_ts;
          pulse_seq   = exp_seq;
        end
        act_q.push_back(src_data_o);
        if (exp_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
        else chk("beat_data", {32'd0, src_data_o}, {32'd0, exp_q.pop_front()});
        chk("beat_sop", {63'd0, src_sop_o}, (beat_idx == 0) ? 64'd1 : 64'd0);
        chk("beat_eop", {63'd0, src_eop_o}, (beat_idx == FW - 1) ? 64'd1 : 64'd0);
        if (beat_idx == FW - 1) begin
          in_frame     = 0;
          exp_seq      = exp_seq + 32'd1;
          eop_cnt++;
          gap_counting = 1;
          gap_len      = 0;
        end else beat_idx++;
      end else if (src_valid_o) begin
        stall_pend = 1;
        hold_data  = src_data_o;
        hold_sop   = src_sop_o;
        hold_eop   = src_eop_o;
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic start_burst(input logic [31:0] fc, input logic [31:0] gp,
                             input logic [47:0] d, input logic [47:0] s);
    frame_cnt_i = fc;
    gap_i       = gp;
    dst_mac_i   = d;
    src_mac_i   = s;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name, input int maxc);
    for (int k = 0; k < maxc && busy_o; k++) begin
      @(posedge clk); #1;
    end
    chk(name, {63'd0, busy_o}, 64'd0);
  endtask

  task automatic wait_sop(input int target, input int maxc);
    for (int k = 0; k < maxc && sop_cnt < target; k++) begin
      @(posedge clk); #1;
    end
    chk("wait_sop_timeout", (sop_cnt >= target) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic wait_eop(input int target, input int maxc);
    for (int k = 0; k < maxc && eop_cnt < target; k++) begin
      @(posedge clk); #1;
    end
    chk("wait_eop_timeout", (eop_cnt >= target) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, src_valid_o}, 64'd0);
    chk({tag, "_data"}, {32'd0, src_data_o}, 64'd0);
    chk({tag, "_sop_eop"}, {62'd0, src_sop_o, src_eop_o}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_ts"}, ts_o, 64'd0);
    chk({tag, "_stamp"}, tx_stamp_o, 64'd0);
    chk({tag, "_seq"}, {32'd0, tx_seq_o}, 64'd0);
    chk({tag, "_stamp_valid"}, {63'd0, tx_stamp_valid_o}, 64'd0);
    chk({tag, "_state"}, {62'd0, dbg_state_o}, 64'd0);
  endtask

  // ---------------- directed tests ----------------
  int s0;
  int e0;

  initial begin
    srst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; src_ready_i = 1'b1;
    frame_cnt_i = '0; gap_i = '0; dst_mac_i = '0; src_mac_i = '0;
    repeat (3) @(posedge clk);
    #1 srst_i = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // single frame
    act_q.delete();
    start_burst(32'd1, 32'd0, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F);
    wait_idle("single_idle", 100);
    chk("single_beats", act_q.size(), 64'd15);
    chk("single_w0", {32'd0, act_q[0]}, 64'h0011_2233);
    chk("single_w1", {32'd0, act_q[1]}, 64'h4455_0A0B);
    chk("single_w2", {32'd0, act_q[2]}, 64'h0C0D_0E0F);
    chk("single_w3", {32'd0, act_q[3]}, 64'h88B5_0000);
    chk("single_w4", {32'd0, act_q[4]}, 64'd0);
    chk("single_w14", {32'd0, act_q[14]}, 64'hA5A5_A5A5);
    chk("single_stamp_words", {act_q[5], act_q[6]}, tx_stamp_o);
    chk("single_stamp_ts", tx_stamp_o - start_ts, 64'd1);
    chk("single_seq", {32'd0, tx_seq_o}, 64'd0);

    // burst with gap
    pseq_q.delete(); pstamp_q.delete(); gap_lens.delete();
    s0 = sop_cnt;
    start_burst(32'd3, 32'd5, 48'h1111_2222_3333, 48'h4444_5555_6666);
    wait_idle("burst_idle", 200);
    idle_cycles(2);
    chk("burst_frames", sop_cnt - s0, 64'd3);
    chk("burst_pulses", pseq_q.size(), 64'd3);
    chk("burst_seq0", {32'd0, pseq_q[0]}, 64'd0);
    chk("burst_seq1", {32'd0, pseq_q[1]}, 64'd1);
    chk("burst_seq2", {32'd0, pseq_q[2]}, 64'd2);
    chk("burst_dstamp01", pstamp_q[1] - pstamp_q[0], 64'd20);
    chk("burst_dstamp12", pstamp_q[2] - pstamp_q[1], 64'd20);
    chk("burst_gaps", gap_lens.size(), 64'd2);
    chk("burst_gap0", gap_lens[0], 64'd5);
    chk("burst_gap1", gap_lens[1], 64'd5);

    // random backpressure
    s0 = sop_cnt;
    start_burst(32'd3, 32'd2, 48'hDEAD_BEEF_0001, 48'hCAFE_F00D_0002);
    for (int k = 0; k < 2000 && busy_o; k++) begin
      src_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    src_ready_i = 1'b1;
    wait_idle("bp_idle", 20);
    chk("bp_frames", sop_cnt - s0, 64'd3);
    chk("bp_queue_empty", exp_q.size(), 64'd0);

    // w0 stalled 4 cycles shifts the stamp by 4
    src_ready_i = 1'b0;
    start_burst(32'd1, 32'd0, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F);
    idle_cycles(4);
    src_ready_i = 1'b1;
    wait_idle("stall_idle", 100);
    chk("stall_stamp", tx_stamp_o - start_ts, 64'd5);

    // stop mid frame 2 of unlimited burst
    s0 = sop_cnt;
    start_burst(32'd0, 32'd1, 48'h0102_0304_0506, 48'h0708_090A_0B0C);
    wait_sop(s0 + 2, 200);
    idle_cycles(3);
    pulse_stop();
    wait_idle("stop_idle", 100);
    idle_cycles(30);
    chk("stop_frames", sop_cnt - s0, 64'd2);
    chk("stop_queue_empty", exp_q.size(), 64'd0);

    // stop during gap
    s0 = sop_cnt;
    e0 = eop_cnt;
    start_burst(32'd0, 32'd8, 48'h0102_0304_0506, 48'h0708_090A_0B0C);
    wait_eop(e0 + 1, 100);
    idle_cycles(2);
    pulse_stop();
    wait_idle("gapstop_idle", 3);
    idle_cycles(20);
    chk("gapstop_frames", sop_cnt - s0, 64'd1);

    // reset mid-frame
    s0 = sop_cnt;
    start_burst(32'd0, 32'd1, 48'hAAAA_BBBB_CCCC, 48'hDDDD_EEEE_FFFF);
    wait_sop(s0 + 1, 50);
    idle_cycles(7);
    srst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    srst_i = 1'b0;
    pseq_q.delete();
    start_burst(32'd1, 32'd3, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F);
    wait_idle("rst_restart_idle", 100);
    idle_cycles(2);
    chk("rst_restart_pulses", pseq_q.size(), 64'd1);
    chk("rst_restart_seq", {32'd0, tx_seq_o}, 64'd0);
    chk("rst_restart_queue", exp_q.size(), 64'd0);

    // gap_i = 0 behaves as 1
    gap_lens.delete();
    start_burst(32'd2, 32'd0, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F);
    wait_idle("gap0_idle", 100);
    chk("gap0_count", gap_lens.size(), 64'd1);
    chk("gap0_len", gap_lens[0], 64'd1);

    // start while busy is ignored
    s0 = sop_cnt;
    start_burst(32'd2, 32'd3, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765);
    idle_cycles(5);
    start_burst(32'd5, 32'd9, 48'hFFFF_FFFF_FFFF, 48'hEEEE_EEEE_EEEE);
    wait_idle("busy_start_idle", 200);
    idle_cycles(20);
    chk("busy_start_frames", sop_cnt - s0, 64'd2);

    // frame_cnt = 1 with stop on the EOP beat, then a clean follow-on burst
    s0 = sop_cnt;
    start_burst(32'd1, 32'd0, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F);
    idle_cycles(14);
    chk("eopstop_on_eop", {63'd0, src_eop_o}, 64'd1);
    pulse_stop();
    wait_idle("eopstop_idle", 10);
    idle_cycles(20);
    chk("eopstop_frames", sop_cnt - s0, 64'd1);
    s0 = sop_cnt;
    start_burst(32'd2, 32'd1, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F);
    wait_idle("after_stop_idle", 100);
    chk("after_stop_frames", sop_cnt - s0, 64'd2);

    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
